// File: rtl/com_slink_pkg.sv
// Shared definitions for the serial-link channel selector: FSM state
// encoding and the channel select constants.
package com_slink_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_ACT_A  = 3'd1,
    ST_ACT_B  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_FAIL   = 3'd4
  } slink_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/com_slink_chn_health.sv
// Per-channel health tracker: counts consecutive error-free end-of-packet
// strobes and flags the channel healthy once the count reaches STABLE_PKT
// while no error is present.
module com_slink_chn_health #(
  parameter logic [7:0] STABLE_PKT = 8'd8
) (
  input  logic clk_125m,
  input  logic rst_125m,
  input  logic chn_err,
  input  logic chn_eop,
  output logic healthy
);

  logic [7:0] good_cnt;

  // Good-packet counter: error clears (and wins over a coincident eop),
  // a clean eop advances, the count parks at STABLE_PKT.
  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      good_cnt <= 8'd0;
    end else if (chn_err) begin
      good_cnt <= 8'd0;
    end else if (chn_eop && (good_cnt != STABLE_PKT)) begin
      good_cnt <= good_cnt + 8'd1;
    end
  end

  // Healthy needs both a full run of clean packets and no error right now.
  always_comb begin
    healthy = !chn_err && (good_cnt == STABLE_PKT);
  end

endmodule

// File: rtl/com_slink_chn_sel.sv
// Redundant serial-link channel selector. Picks channel A or B, fails over
// on a diagnosed error of the active channel through a blanking interval,
// honours a manual force request, and never reverts on its own.
module com_slink_chn_sel
  import com_slink_pkg::*;
#(
  parameter logic [7:0]  STABLE_PKT  = 8'd8,
  parameter logic [15:0] SWITCH_HOLD = 16'd1250
) (
  input  logic       clk_125m,
  input  logic       rst_125m,
  input  logic       chn_a_err,
  input  logic       chn_b_err,
  input  logic       chn_a_eop,
  input  logic       chn_b_eop,
  input  logic       force_en,
  input  logic       force_sel,
  output logic       sel_chn,
  output logic       sel_valid,
  output logic       both_err,
  output logic [7:0] switch_cnt
);

  slink_state_e state, state_nxt;
  logic         target, target_nxt;
  logic [15:0]  hold_cnt;
  logic         last_sel;
  logic         healthy_a, healthy_b;
  logic         target_healthy;
  logic         switch_entry;

  com_slink_chn_health #(.STABLE_PKT(STABLE_PKT)) u_health_a (
    .clk_125m (clk_125m),
    .rst_125m (rst_125m),
    .chn_err  (chn_a_err),
    .chn_eop  (chn_a_eop),
    .healthy  (healthy_a)
  );

  com_slink_chn_health #(.STABLE_PKT(STABLE_PKT)) u_health_b (
    .clk_125m (clk_125m),
    .rst_125m (rst_125m),
    .chn_err  (chn_b_err),
    .chn_eop  (chn_b_eop),
    .healthy  (healthy_b)
  );

  always_comb begin
    target_healthy = (target == SEL_B) ? healthy_b : healthy_a;
    switch_entry   = (state_nxt == ST_SWITCH) && (state != ST_SWITCH);
  end

  // State register with the switchover target latched alongside.
  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      state  <= ST_INIT;
      target <= SEL_A;
    end else begin
      state  <= state_nxt;
      target <= target_nxt;
    end
  end

  // Next-state logic; an active-channel error outranks a force request.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    case (state)
      ST_INIT: begin
        if (force_en && (force_sel == SEL_B) && healthy_b) begin
          state_nxt = ST_ACT_B;
        end else if (healthy_a) begin
          state_nxt = ST_ACT_A;
        end else if (healthy_b) begin
          state_nxt = ST_ACT_B;
        end
      end
      ST_ACT_A: begin
        if (chn_a_err) begin
          if (healthy_b) begin
            state_nxt  = ST_SWITCH;
            target_nxt = SEL_B;
          end else begin
            state_nxt = ST_FAIL;
          end
        end else if (force_en && (force_sel == SEL_B) && healthy_b) begin
          state_nxt  = ST_SWITCH;
          target_nxt = SEL_B;
        end
      end
      ST_ACT_B: begin
        if (chn_b_err) begin
          if (healthy_a) begin
            state_nxt  = ST_SWITCH;
            target_nxt = SEL_A;
          end else begin
            state_nxt = ST_FAIL;
          end
        end else if (force_en && (force_sel == SEL_A) && healthy_a) begin
          state_nxt  = ST_SWITCH;
          target_nxt = SEL_A;
        end
      end
      ST_SWITCH: begin
        if (hold_cnt == (SWITCH_HOLD - 16'd1)) begin
          if (target_healthy) begin
            state_nxt = (target == SEL_B) ? ST_ACT_B : ST_ACT_A;
          end else begin
            state_nxt = ST_FAIL;
          end
        end
      end
      ST_FAIL: begin
        if (force_en && ((force_sel == SEL_B) ? healthy_b : healthy_a)) begin
          state_nxt  = ST_SWITCH;
          target_nxt = force_sel;
        end else if (healthy_a) begin
          state_nxt  = ST_SWITCH;
          target_nxt = SEL_A;
        end else if (healthy_b) begin
          state_nxt  = ST_SWITCH;
          target_nxt = SEL_B;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Blanking counter: restarts on every entry into SWITCH.
  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      hold_cnt <= 16'd0;
    end else if (switch_entry) begin
      hold_cnt <= 16'd0;
    end else if (state == ST_SWITCH) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  // Switchover statistics, one per SWITCH entry, parking at 255.
  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      switch_cnt <= 8'd0;
    end else if (switch_entry && (switch_cnt != 8'hFF)) begin
      switch_cnt <= switch_cnt + 8'd1;
    end
  end

  // Remember the last driven selection so INIT/FAIL can hold it.
  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      last_sel <= SEL_A;
    end else begin
      last_sel <= sel_chn;
    end
  end

  // Moore output decode; forced low while reset is asserted.
  always_comb begin
    sel_valid = 1'b0;
    both_err  = 1'b0;
    sel_chn   = last_sel;
    case (state)
      ST_ACT_A: begin
        sel_valid = 1'b1;
        sel_chn   = SEL_A;
      end
      ST_ACT_B: begin
        sel_valid = 1'b1;
        sel_chn   = SEL_B;
      end
      ST_SWITCH: begin
        sel_chn = target;
      end
      ST_FAIL: begin
        both_err = 1'b1;
      end
      default: begin
        sel_chn = last_sel;
      end
    endcase
    if (rst_125m) begin
      sel_valid = 1'b0;
      both_err  = 1'b0;
      sel_chn   = 1'b0;
    end
  end

endmodule

// File: tb/tb_com_slink_chn_sel.sv
// Directed bench for the channel selector (STABLE_PKT=8, SWITCH_HOLD=16).
module tb_com_slink_chn_sel;

  logic       clk_125m;
  logic       rst_125m;
  logic       chn_a_err;
  logic       chn_b_err;
  logic       chn_a_eop;
  logic       chn_b_eop;
  logic       force_en;
  logic       force_sel;
  logic       sel_chn;
  logic       sel_valid;
  logic       both_err;
  logic [7:0] switch_cnt;

  int checks;
  int errors;

  com_slink_chn_sel #(
    .STABLE_PKT  (8'd8),
    .SWITCH_HOLD (16'd16)
  ) dut (
    .clk_125m   (clk_125m),
    .rst_125m   (rst_125m),
    .chn_a_err  (chn_a_err),
    .chn_b_err  (chn_b_err),
    .chn_a_eop  (chn_a_eop),
    .chn_b_eop  (chn_b_eop),
    .force_en   (force_en),
    .force_sel  (force_sel),
    .sel_chn    (sel_chn),
    .sel_valid  (sel_valid),
    .both_err   (both_err),
    .switch_cnt (switch_cnt)
  );

  initial clk_125m = 1'b0;
  always #4 clk_125m = ~clk_125m;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_125m);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eops(input logic on_a, input logic on_b, input int n);
    for (int i = 0; i < n; i++) begin
      chn_a_eop = on_a;
      chn_b_eop = on_b;
      step(1);
      chn_a_eop = 1'b0;
      chn_b_eop = 1'b0;
    end
  endtask

  // Wait (bounded) until the given channel is active and usable.
  task automatic wait_act(input logic want, input string tag);
    int n;
    n = 0;
    while (!(sel_valid === 1'b1 && sel_chn === want) && n < 100) begin
      step(1);
      n++;
    end
    chk(tag, (n < 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int  lowcnt;
    logic want;
    checks    = 0;
    errors    = 0;
    rst_125m  = 1'b1;
    chn_a_err = 1'b0;
    chn_b_err = 1'b0;
    chn_a_eop = 1'b0;
    chn_b_eop = 1'b0;
    force_en  = 1'b0;
    force_sel = 1'b0;

    // Reset state
    step(3);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_sel_chn", sel_chn, 0);
    chk("rst_both_err", both_err, 0);
    chk("rst_switch_cnt", switch_cnt, 0);
    rst_125m = 1'b0;
    step(1);
    chk("init_sel_valid", sel_valid, 0);

    // Start-up: 8 clean A eops, ACT_A one cycle after the 8th
    eops(1'b1, 1'b0, 8);
    chk("startup_pre_valid", sel_valid, 0);
    step(1);
    chk("startup_valid", sel_valid, 1);
    chk("startup_chn", sel_chn, 0);

    // B becomes healthy: no change while A is fine
    eops(1'b0, 1'b1, 8);
    step(2);
    chk("b_ok_stay_chn", sel_chn, 0);
    chk("b_ok_stay_cnt", switch_cnt, 0);

    // Failover A -> B: 16 blanking cycles
    chn_a_err = 1'b1;
    step(1);
    chk("fo_sw_chn", sel_chn, 1);
    chk("fo_sw_cnt", switch_cnt, 1);
    chk("fo_sw_both_err", both_err, 0);
    lowcnt = 0;
    while (sel_valid === 1'b0 && lowcnt < 40) begin
      lowcnt++;
      step(1);
    end
    chk("fo_blank_len", lowcnt, 16);
    chk("fo_act_b_chn", sel_chn, 1);
    chk("fo_act_b_cnt", switch_cnt, 1);
    chn_a_err = 1'b0;

    // Non-revert: A recovers while B active
    eops(1'b1, 1'b0, 8);
    step(3);
    chk("nonrevert_chn", sel_chn, 1);
    chk("nonrevert_valid", sel_valid, 1);
    chk("nonrevert_cnt", switch_cnt, 1);

    // Force back to A
    force_en  = 1'b1;
    force_sel = 1'b0;
    step(1);
    chk("force_a_sw_valid", sel_valid, 0);
    wait_act(1'b0, "force_a_wait");
    force_en = 1'b0;
    chk("force_a_cnt", switch_cnt, 2);

    // Force and error together: exactly one switchover to B
    force_en  = 1'b1;
    force_sel = 1'b1;
    chn_a_err = 1'b1;
    step(1);
    chk("fe_sw_chn", sel_chn, 1);
    chk("fe_sw_cnt", switch_cnt, 3);
    wait_act(1'b1, "fe_wait");
    step(3);
    chk("fe_one_switch_cnt", switch_cnt, 3);
    chk("fe_chn", sel_chn, 1);
    force_en  = 1'b0;
    chn_a_err = 1'b0;

    // Back to A for the double-fault case
    eops(1'b1, 1'b0, 8);
    force_en  = 1'b1;
    force_sel = 1'b0;
    step(1);
    wait_act(1'b0, "df_prep_wait");
    force_en = 1'b0;
    chk("df_prep_cnt", switch_cnt, 4);

    // Double fault -> FAIL, then B recovers -> SWITCH -> ACT_B
    chn_a_err = 1'b1;
    chn_b_err = 1'b1;
    step(1);
    chk("df_both_err", both_err, 1);
    chk("df_valid", sel_valid, 0);
    chk("df_hold_chn", sel_chn, 0);
    chn_b_err = 1'b0;
    eops(1'b0, 1'b1, 8);
    chk("df_still_fail", both_err, 1);
    step(1);
    chk("df_sw_both_err", both_err, 0);
    chk("df_sw_chn", sel_chn, 1);
    chk("df_sw_valid", sel_valid, 0);
    chk("df_sw_cnt", switch_cnt, 5);
    wait_act(1'b1, "df_wait_b");
    chn_a_err = 1'b0;

    // Saturation: 300 forced toggles from ACT_B
    eops(1'b1, 1'b0, 8);
    force_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      want      = (i % 2 == 0) ? 1'b0 : 1'b1;
      force_sel = want;
      step(1);
      wait_act(want, "toggle_wait");
      if (i == 248) chk("sat_254", switch_cnt, 254);
    end
    chk("sat_255", switch_cnt, 255);
    chk("sat_chn", sel_chn, 1);

    // Reset at hold cycle 5 of a switchover
    force_sel = 1'b0;
    step(1);
    chk("rsw_in_switch", sel_valid, 0);
    chk("rsw_cnt_sat", switch_cnt, 255);
    step(5);
    rst_125m = 1'b1;
    force_en = 1'b0;
    step(1);
    chk("rsw_sel_chn", sel_chn, 0);
    chk("rsw_valid", sel_valid, 0);
    chk("rsw_both_err", both_err, 0);
    chk("rsw_cnt", switch_cnt, 0);
    rst_125m = 1'b0;
    step(3);
    chk("rsw_init_valid", sel_valid, 0);
    chk("rsw_init_cnt", switch_cnt, 0);
    chk("rsw_init_chn", sel_chn, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/com_slink_chn_sel.md
COM_SLINK_CHN_SEL -- requirements
Module: com_slink_chn_sel

Interface
REQ-001 SHALL have parameter STABLE_PKT, default 8'd8: consecutive error-free EOPs before a channel counts as healthy.
REQ-002 SHALL have parameter SWITCH_HOLD, default 16'd1250: blanking cycles during a switchover (10 us at 125 MHz).
REQ-003 SHALL have port clk_125m  input  1  sole clock.
REQ-004 SHALL have port rst_125m  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port chn_a_err  input  1  diagnosed link error, channel A, level.
REQ-006 SHALL have port chn_b_err  input  1  diagnosed link error, channel B, level.
REQ-007 SHALL have port chn_a_eop  input  1  end-of-packet strobe, channel A, one cycle.
REQ-008 SHALL have port chn_b_eop  input  1  end-of-packet strobe, channel B, one cycle.
REQ-009 SHALL have port force_en  input  1  manual selection override enable.
REQ-010 SHALL have port force_sel  input  1  forced channel, 0=A, 1=B.
REQ-011 SHALL have port sel_chn  output  1  selected channel, 0=A, 1=B.
REQ-012 SHALL have port sel_valid  output  1  selected channel usable.
REQ-013 SHALL have port both_err  output  1  no healthy channel available.
REQ-014 SHALL have port switch_cnt  output  8  switchover count, saturating.

Function
REQ-015 SHALL keep a per-channel good counter: cleared while err=1; +1 on eop with err=0; saturates at STABLE_PKT.
REQ-016 SHALL define healthy_x = (err_x==0) && (good_x==STABLE_PKT); err and eop high in the same cycle clear the counter.
REQ-017 SHALL implement the FSM states INIT, ACT_A, ACT_B, SWITCH and FAIL, with a registered target bit used in SWITCH.
REQ-018 INIT SHALL go to ACT_A if healthy_a, else to ACT_B if healthy_b, else stay; with force_en=1, the forced channel SHALL be tried first.
REQ-019 ACT_A SHALL act on chn_a_err=1 as follows: go to SWITCH with target=B if healthy_b, else go to FAIL. ACT_B SHALL behave symmetrically.
REQ-020 ACT_x SHALL go to SWITCH (target=force_sel) when force_en=1, force_sel differs from x, and the target is healthy; an active-channel error SHALL take priority over a force request in the same cycle.
REQ-021 Selection SHALL be non-revertive: recovery of the inactive channel alone SHALL cause no transition.
REQ-022 SWITCH SHALL count SWITCH_HOLD cycles from 0; at count SWITCH_HOLD-1 it SHALL go to ACT_target if the target is healthy, else to FAIL; the hold counter SHALL clear on entry to SWITCH.
REQ-023 FAIL SHALL go to SWITCH with target = forced channel if force_en=1 and that channel is healthy; otherwise target=A if healthy_a, else target=B if healthy_b; otherwise it SHALL stay.
REQ-024 Outputs SHALL be Moore-decoded from the registered state.
REQ-025 sel_valid SHALL be 1 only in ACT_A and ACT_B.
REQ-026 sel_chn SHALL be 0 in ACT_A, 1 in ACT_B, and equal to target in SWITCH; it SHALL hold its last value in INIT and FAIL.
REQ-027 both_err SHALL be 1 only in FAIL.
REQ-028 Latency: an error sampled at edge N SHALL change state at edge N and drop sel_valid in the cycle following edge N.
REQ-029 switch_cnt SHALL increment once per entry into SWITCH and saturate at 8'hFF.

Reset
REQ-030 While rst_125m=1 at a clock edge, state SHALL be INIT, target SHALL be 0, and the good counters, hold counter and switch_cnt SHALL be 0.
REQ-031 During reset, sel_chn, sel_valid and both_err SHALL be 0.
REQ-032 Reset asserted mid-SWITCH SHALL abort the hold with no count increment.

Structure
REQ-033 The state encoding and SEL_A/SEL_B constants SHALL reside in shared package com_slink_pkg.
REQ-034 The good-packet counter SHALL be sub-module com_slink_chn_health, instantiated once per channel.

Verification (STABLE_PKT=8, SWITCH_HOLD=16)
REQ-035 Start-up: release reset, then 8 clean A eops -> ACT_A; sel_valid=1 and sel_chn=0 one cycle after the 8th eop.
REQ-036 Failover: in ACT_A with B healthy, raise chn_a_err -> sel_valid=0 for 16 cycles, sel_chn=1, then ACT_B with sel_valid=1; switch_cnt=1.
REQ-037 Double fault: in ACT_A, raise chn_a_err and chn_b_err together -> FAIL, both_err=1; then 8 clean B eops -> SWITCH then ACT_B, with both_err low during SWITCH.
REQ-038 Force vs error: in ACT_A with B healthy, assert force_en=1, force_sel=1 in the same cycle as chn_a_err -> exactly one SWITCH to B; switch_cnt increments by 1.
REQ-039 Non-revert and saturation: in ACT_B, A recovering causes no switch; 300 forced toggles -> switch_cnt stays at 255.
REQ-040 Reset during SWITCH at hold cycle 5 -> all outputs 0 and INIT; switch_cnt=0.
